uart_parity_engine: RTL and testbench
=====================================

Name: uart_parity_engine

Overview:
- Bit-serial parity generator/checker shared by the TX and RX cores.
- Accumulates parity one data bit at a time on a per-bit strobe, so the result is correct for both the TX shift path and the RX sampling path.
- Supports runtime data length 5..DATA_WIDTH and five parity modes (none/even/odd/mark/space).
- On RX, it compares the received parity bit and flags errors with a pulse and a sticky flag.

Parameters:
DATA_WIDTH, 8, maximum data bits per frame; legal range 5..9.
CNT_W, 4, width of the bit counter; must satisfy 2^CNT_W > DATA_WIDTH.

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous, active-low reset; released synchronously to clk.
p_Start_i  in  1  one-cycle pulse at start-bit time; begins a new frame and aborts any frame in progress.
p_BitStrobe_i  in  1  one-cycle pulse per data bit (TX shift / RX sample instant).
BitValue_i  in  1  data bit value, qualified by p_BitStrobe_i.
DataLength_i  in  4  data bits per frame; latched at p_Start_i.
ParityMode_i  in  3  000 none, 001 even, 010 odd, 011 mark, 100 space; 101..111 treated as none; latched at p_Start_i.
p_ParityStrobe_i  in  1  one-cycle pulse when the RX parity bit is sampled.
ParityBit_i  in  1  received parity bit, qualified by p_ParityStrobe_i.
p_ErrClear_i  in  1  clears ErrorSticky_o.
ParityResult_o  out  1  generated/expected parity bit.
ParityValid_o  out  1  high while ParityResult_o is valid for the current frame.
p_ParityError_o  out  1  one-cycle error pulse.
ErrorSticky_o  out  1  sticky parity error flag.
Busy_o  out  1  high in ACCUM and READY.
BitCount_o  out  CNT_W  data bits accumulated in the current frame.

Behaviour:
- Reset: ParityResult_o=1, ParityValid_o=0, p_ParityError_o=0, ErrorSticky_o=0, Busy_o=0, BitCount_o=0, FSM=IDLE, accumulator=0.
- The FSM is one-hot with states IDLE, ACCUM, READY.
- Length clamp at latch time: values <5 become 5; values >DATA_WIDTH become DATA_WIDTH (len_r).
- p_Start_i, in any state:
  - Next state ACCUM; acc=0; BitCount_o=0; mode and length latched.
  - ParityValid_o=0; ParityResult_o=1.
  - p_Start_i has priority over a coincident p_BitStrobe_i or p_ParityStrobe_i, which are ignored that cycle.
- ACCUM:
  - Each p_BitStrobe_i does acc ^= BitValue_i and BitCount_o += 1.
  - On the strobe that brings the count to len_r:
    - mode none: go to IDLE; ParityValid_o stays 0; ParityResult_o stays 1.
    - otherwise: go to READY.
  - Latency: ParityResult_o and ParityValid_o are registered and valid on the cycle after the final strobe (1-cycle latency).
  - ParityResult_o per mode: even = acc; odd = ~acc; mark = 1; space = 0.
  - p_ParityStrobe_i in ACCUM is ignored.
- READY:
  - ParityResult_o and ParityValid_o are held.
  - Further p_BitStrobe_i are ignored; the count saturates at len_r.
  - p_ParityStrobe_i:
    - If ParityBit_i != ParityResult_o: p_ParityError_o=1 for exactly one cycle (the next cycle), and ErrorSticky_o is set.
    - Then, in all cases, next state IDLE and ParityValid_o=0.
  - TX use: the TX core reads ParityResult_o in READY and issues p_Start_i for the next frame; no p_ParityStrobe_i is needed.
- IDLE:
  - All strobes except p_Start_i are ignored.
  - ParityResult_o=1 (idle line level); BitCount_o keeps its last value.
- ErrorSticky_o:
  - Set on any parity error; cleared by p_ErrClear_i.
  - A set and a clear in the same cycle: set wins.
- Reset asserted mid-frame returns every output to its reset value immediately (asynchronously).
- Back-to-back frames: p_Start_i on the same cycle as p_ParityStrobe_i starts the new frame and drops the check, per the priority rule above.

Test Plan:
- 8 bits, even, data 0xA5 (LSB first): result 0, Valid=1 on the cycle after the 8th strobe; repeat with odd: result 1.
- 7 bits, even, bits 1,1,0,0,1,0,1, then ParityBit_i=1: p_ParityError_o pulses once, ErrorSticky_o=1; p_ErrClear_i clears it. ParityBit_i=0 gives no error.
- Mark and space, 5 bits, data 0x1F: results 1 and 0 respectively; mode none: FSM returns to IDLE after the 5th strobe, Valid never asserts.
- Clamp: DataLength_i=3 gives READY after 5 strobes; DataLength_i=15 with DATA_WIDTH=8 gives READY after 8 strobes.
- p_Start_i after 4 strobes of a frame, coincident with a strobe: BitCount_o=0, acc cleared; the next 8-bit 0x01 even frame gives result 1.
- rst low mid-ACCUM and during READY: all outputs at reset values; a subsequent 0xFF even frame gives result 0.

Source files
------------

// File: rtl/uart_parity_engine.sv
// Bit-serial parity generator/checker shared by the UART TX and RX paths.
// Parity accumulates one data bit per strobe; on RX the sampled parity bit is checked against it.
module uart_parity_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             p_Start_i,
    input  logic             p_BitStrobe_i,
    input  logic             BitValue_i,
    input  logic [3:0]       DataLength_i,
    input  logic [2:0]       ParityMode_i,
    input  logic             p_ParityStrobe_i,
    input  logic             ParityBit_i,
    input  logic             p_ErrClear_i,
    output logic             ParityResult_o,
    output logic             ParityValid_o,
    output logic             p_ParityError_o,
    output logic             ErrorSticky_o,
    output logic             Busy_o,
    output logic [CNT_W-1:0] BitCount_o
);

    localparam logic [2:0] ST_IDLE  = 3'b001;
    localparam logic [2:0] ST_ACCUM = 3'b010;
    localparam logic [2:0] ST_READY = 3'b100;

    localparam logic [3:0] MIN_LEN = 4'd5;
    localparam logic [3:0] MAX_LEN = 4'(DATA_WIDTH);

    localparam logic [2:0] MODE_EVEN  = 3'b001;
    localparam logic [2:0] MODE_ODD   = 3'b010;
    localparam logic [2:0] MODE_MARK  = 3'b011;
    localparam logic [2:0] MODE_SPACE = 3'b100;

    logic [2:0]       state_q, state_d;
    logic             acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [2:0]       mode_q, mode_d;
    logic             result_q, result_d;
    logic             valid_q, valid_d;
    logic             perr_q, perr_d;
    logic             sticky_q, sticky_d;

    logic [CNT_W-1:0] len_clamped;
    logic [CNT_W-1:0] cnt_inc;
    logic             acc_next;
    logic             mode_none;
    logic             parity_calc;

    always_comb begin
        if (DataLength_i < MIN_LEN) begin
            len_clamped = CNT_W'(MIN_LEN);
        end else if (DataLength_i > MAX_LEN) begin
            len_clamped = CNT_W'(MAX_LEN);
        end else begin
            len_clamped = CNT_W'(DataLength_i);
        end
    end

    assign cnt_inc  = cnt_q + CNT_W'(1);
    assign acc_next = acc_q ^ BitValue_i;

    // Reserved encodings 101..111 behave exactly like "none".
    always_comb begin
        mode_none   = 1'b0;
        parity_calc = 1'b1;
        case (mode_q)
            MODE_EVEN:  parity_calc = acc_next;
            MODE_ODD:   parity_calc = ~acc_next;
            MODE_MARK:  parity_calc = 1'b1;
            MODE_SPACE: parity_calc = 1'b0;
            default:    mode_none   = 1'b1;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        mode_d   = mode_q;
        result_d = result_q;
        valid_d  = valid_q;
        perr_d   = 1'b0;
        sticky_d = p_ErrClear_i ? 1'b0 : sticky_q;

        if (p_Start_i) begin
            state_d  = ST_ACCUM;
            acc_d    = 1'b0;
            cnt_d    = '0;
            len_d    = len_clamped;
            mode_d   = ParityMode_i;
            result_d = 1'b1;
            valid_d  = 1'b0;
        end else begin
            case (state_q)
                ST_ACCUM: begin
                    if (p_BitStrobe_i) begin
                        acc_d = acc_next;
                        cnt_d = cnt_inc;
                        if (cnt_inc == len_q) begin
                            if (mode_none) begin
                                state_d = ST_IDLE;
                            end else begin
                                state_d  = ST_READY;
                                result_d = parity_calc;
                                valid_d  = 1'b1;
                            end
                        end
                    end
                end
                ST_READY: begin
                    if (p_ParityStrobe_i) begin
                        if (ParityBit_i != result_q) begin
                            perr_d   = 1'b1;
                            sticky_d = 1'b1;
                        end
                        state_d  = ST_IDLE;
                        valid_d  = 1'b0;
                        result_d = 1'b1;
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    result_d = 1'b1;
                    valid_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            acc_q    <= 1'b0;
            cnt_q    <= '0;
            len_q    <= CNT_W'(MIN_LEN);
            mode_q   <= 3'b000;
            result_q <= 1'b1;
            valid_q  <= 1'b0;
            perr_q   <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            mode_q   <= mode_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            perr_q   <= perr_d;
            sticky_q <= sticky_d;
        end
    end

    assign ParityResult_o  = result_q;
    assign ParityValid_o   = valid_q;
    assign p_ParityError_o = perr_q;
    assign ErrorSticky_o   = sticky_q;
    assign Busy_o          = (state_q == ST_ACCUM) || (state_q == ST_READY);
    assign BitCount_o      = cnt_q;

endmodule

// File: tb/tb_uart_parity_engine.sv
// Directed-vector bench for uart_parity_engine; expected values are hand-computed.
module tb_uart_parity_engine;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       p_Start_i = 1'b0;
    logic       p_BitStrobe_i = 1'b0;
    logic       BitValue_i = 1'b0;
    logic [3:0] DataLength_i = 4'd8;
    logic [2:0] ParityMode_i = 3'b000;
    logic       p_ParityStrobe_i = 1'b0;
    logic       ParityBit_i = 1'b0;
    logic       p_ErrClear_i = 1'b0;
    logic       ParityResult_o;
    logic       ParityValid_o;
    logic       p_ParityError_o;
    logic       ErrorSticky_o;
    logic       Busy_o;
    logic [3:0] BitCount_o;

    int vectors = 0;
    int miscompares = 0;

    uart_parity_engine #(.DATA_WIDTH(8), .CNT_W(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .p_Start_i        (p_Start_i),
        .p_BitStrobe_i    (p_BitStrobe_i),
        .BitValue_i       (BitValue_i),
        .DataLength_i     (DataLength_i),
        .ParityMode_i     (ParityMode_i),
        .p_ParityStrobe_i (p_ParityStrobe_i),
        .ParityBit_i      (ParityBit_i),
        .p_ErrClear_i     (p_ErrClear_i),
        .ParityResult_o   (ParityResult_o),
        .ParityValid_o    (ParityValid_o),
        .p_ParityError_o  (p_ParityError_o),
        .ErrorSticky_o    (ErrorSticky_o),
        .Busy_o           (Busy_o),
        .BitCount_o       (BitCount_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [3:0] len, input logic [2:0] mode);
        p_Start_i    = 1'b1;
        DataLength_i = len;
        ParityMode_i = mode;
        tick();
        p_Start_i    = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        p_BitStrobe_i = 1'b1;
        BitValue_i    = b;
        tick();
        p_BitStrobe_i = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] data, input int n);
        for (int i = 0; i < n; i++) send_bit(data[i]);
    endtask

    task automatic parity(input logic b);
        p_ParityStrobe_i = 1'b1;
        ParityBit_i      = b;
        tick();
        p_ParityStrobe_i = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_res"},   8'(ParityResult_o),  8'd1);
        chk({tag, "_val"},   8'(ParityValid_o),   8'd0);
        chk({tag, "_perr"},  8'(p_ParityError_o), 8'd0);
        chk({tag, "_stk"},   8'(ErrorSticky_o),   8'd0);
        chk({tag, "_busy"},  8'(Busy_o),          8'd0);
        chk({tag, "_cnt"},   8'(BitCount_o),      8'd0);
    endtask

    initial begin
        #12;
        chk_reset("rst0");
        @(negedge clk);
        rst = 1'b1;
        tick();

        // 8-bit even / odd over 0xA5 (four ones)
        start(4'd8, 3'b001);
        chk("start_val", 8'(ParityValid_o), 8'd0);
        chk("start_busy", 8'(Busy_o), 8'd1);
        send_word(8'hA5, 7);
        chk("even7_val", 8'(ParityValid_o), 8'd0);
        send_bit(1'b1);
        chk("even_val", 8'(ParityValid_o), 8'd1);
        chk("even_res", 8'(ParityResult_o), 8'd0);
        chk("even_cnt", 8'(BitCount_o), 8'd8);
        send_bit(1'b1);
        chk("ready_sat_cnt", 8'(BitCount_o), 8'd8);
        chk("ready_hold_res", 8'(ParityResult_o), 8'd0);

        start(4'd8, 3'b010);
        send_word(8'hA5, 8);
        chk("odd_val", 8'(ParityValid_o), 8'd1);
        chk("odd_res", 8'(ParityResult_o), 8'd1);

        // 7-bit even RX check, bits 1,1,0,0,1,0,1 -> expected parity 0
        start(4'd7, 3'b001);
        p_ParityStrobe_i = 1'b1; ParityBit_i = 1'b1;
        send_bit(1'b1);
        p_ParityStrobe_i = 1'b0;
        send_word(8'h29, 6);
        chk("accum_pstb_perr", 8'(p_ParityError_o), 8'd0);
        chk("rx7_res", 8'(ParityResult_o), 8'd0);
        parity(1'b1);
        chk("rx7_perr", 8'(p_ParityError_o), 8'd1);
        chk("rx7_stk", 8'(ErrorSticky_o), 8'd1);
        chk("rx7_val", 8'(ParityValid_o), 8'd0);
        chk("rx7_busy", 8'(Busy_o), 8'd0);
        chk("rx7_idle_res", 8'(ParityResult_o), 8'd1);
        tick();
        chk("rx7_perr_1cyc", 8'(p_ParityError_o), 8'd0);
        chk("rx7_stk_hold", 8'(ErrorSticky_o), 8'd1);
        p_ErrClear_i = 1'b1; tick(); p_ErrClear_i = 1'b0;
        chk("clr_stk", 8'(ErrorSticky_o), 8'd0);

        start(4'd7, 3'b001);
        send_word(8'h53, 7);
        parity(1'b0);
        chk("rx7ok_perr", 8'(p_ParityError_o), 8'd0);
        chk("rx7ok_stk", 8'(ErrorSticky_o), 8'd0);

        // set and clear together: set wins
        start(4'd7, 3'b001);
        send_word(8'h53, 7);
        p_ErrClear_i = 1'b1;
        parity(1'b1);
        p_ErrClear_i = 1'b0;
        chk("setwins_stk", 8'(ErrorSticky_o), 8'd1);
        p_ErrClear_i = 1'b1; tick(); p_ErrClear_i = 1'b0;

        // mark / space / none with 5 bits of 0x1F
        start(4'd5, 3'b011);
        send_word(8'h1F, 5);
        chk("mark_res", 8'(ParityResult_o), 8'd1);
        chk("mark_val", 8'(ParityValid_o), 8'd1);
        start(4'd5, 3'b100);
        send_word(8'h1F, 5);
        chk("space_res", 8'(ParityResult_o), 8'd0);
        start(4'd5, 3'b000);
        send_word(8'h1F, 5);
        chk("none_busy", 8'(Busy_o), 8'd0);
        chk("none_val", 8'(ParityValid_o), 8'd0);
        chk("none_res", 8'(ParityResult_o), 8'd1);
        chk("none_cnt", 8'(BitCount_o), 8'd5);
        start(4'd5, 3'b110);
        send_word(8'h00, 5);
        chk("rsvd_busy", 8'(Busy_o), 8'd0);

        // length clamp
        start(4'd3, 3'b001);
        send_word(8'h00, 4);
        chk("clamp3_val4", 8'(ParityValid_o), 8'd0);
        send_bit(1'b1);
        chk("clamp3_val5", 8'(ParityValid_o), 8'd1);
        chk("clamp3_res", 8'(ParityResult_o), 8'd1);
        start(4'd15, 3'b001);
        send_word(8'h00, 7);
        chk("clamp15_val7", 8'(ParityValid_o), 8'd0);
        send_bit(1'b0);
        chk("clamp15_val8", 8'(ParityValid_o), 8'd1);
        chk("clamp15_cnt", 8'(BitCount_o), 8'd8);

        // back-to-back: start beats a mismatching parity strobe
        p_ParityStrobe_i = 1'b1; ParityBit_i = 1'b1;
        start(4'd8, 3'b001);
        p_ParityStrobe_i = 1'b0;
        chk("b2b_perr", 8'(p_ParityError_o), 8'd0);
        chk("b2b_stk", 8'(ErrorSticky_o), 8'd0);

        // abort after 4 strobes (acc=1) with a coincident strobe
        send_word(8'h07, 4);
        p_BitStrobe_i = 1'b1; BitValue_i = 1'b1;
        start(4'd8, 3'b001);
        p_BitStrobe_i = 1'b0;
        chk("abort_cnt", 8'(BitCount_o), 8'd0);
        chk("abort_busy", 8'(Busy_o), 8'd1);
        send_word(8'h01, 8);
        chk("abort_res", 8'(ParityResult_o), 8'd1);

        // async reset mid-ACCUM and in READY
        start(4'd8, 3'b001);
        send_word(8'h07, 3);
        #2 rst = 1'b0; #1;
        chk_reset("rstacc");
        @(negedge clk); rst = 1'b1; tick();
        start(4'd8, 3'b010);
        send_word(8'h01, 8);
        #2 rst = 1'b0; #1;
        chk_reset("rstrdy");
        @(negedge clk); rst = 1'b1; tick();
        start(4'd8, 3'b001);
        send_word(8'hFF, 8);
        chk("ff_res", 8'(ParityResult_o), 8'd0);
        chk("ff_val", 8'(ParityValid_o), 8'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
